// File: rtl/ipif_regs_ext_pkg.sv
// Shared definitions for the IPIF register file: handshake states and register-map arithmetic.
package ipif_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } ipif_state_e;

    function automatic int log2_ceil(input int value);
        int bits;
        bits = 32'sd0;
        while ((32'sd1 << bits) < value) begin
            bits = bits + 32'sd1;
        end
        return bits;
    endfunction

    function automatic int at_least_one(input int value);
        return (value > 32'sd0) ? value : 32'sd1;
    endfunction

    function automatic int irq_reg_count(input int irq_width);
        return (irq_width > 32'sd0) ? 32'sd2 : 32'sd0;
    endfunction

    function automatic int total_regs(input int n_wo, input int n_rw, input int n_ro,
                                      input int n_cnt, input int irq_width);
        return n_wo + n_rw + n_ro + n_cnt + irq_reg_count(irq_width);
    endfunction

endpackage

// File: rtl/ipif_regs_ext_if.sv
// Bus2IP/IP2Bus signal bundle between axi_lite_ipif (master) and the register file (slave).
interface ipif_regs_ext_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   Bus2IP_Addr;
    logic            Bus2IP_CS;
    logic            Bus2IP_RNW;
    logic [DW-1:0]   Bus2IP_Data;
    logic [DW/8-1:0] Bus2IP_BE;
    logic [DW-1:0]   IP2Bus_Data;
    logic            IP2Bus_RdAck;
    logic            IP2Bus_WrAck;
    logic            IP2Bus_Error;

    modport master (
        output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

    modport slave (
        input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
endinterface

// File: rtl/ipif_regs_ext_counter.sv
// Saturating event counter, cleared when software reads it; a clear coinciding with an increment leaves one.
module ipif_event_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear-on-read first, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? CNT_WIDTH'(1'b1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/ipif_regs_ext.sv
// IPIF register file: WO/RW/RO/counter regions plus W1C interrupt status/enable, one ack per CS strobe.
module ipif_regs_ext
    import ipif_regs_pkg::*;
#(
    parameter int  C_S_AXI_DATA_WIDTH = 32,
    parameter int  C_S_AXI_ADDR_WIDTH = 32,
    parameter int  NUM_WO_REGS        = 0,
    parameter int  NUM_RW_REGS        = 0,
    parameter int  NUM_RO_REGS        = 0,
    parameter int  NUM_CNT_REGS       = 0,
    parameter int  CNT_WIDTH          = 32,
    parameter int  IRQ_WIDTH          = 0,
    localparam int DW                 = C_S_AXI_DATA_WIDTH,
    localparam int BW                 = DW / 8,
    localparam int WO_A               = at_least_one(NUM_WO_REGS),
    localparam int RW_A               = at_least_one(NUM_RW_REGS),
    localparam int RO_A               = at_least_one(NUM_RO_REGS),
    localparam int CNT_A              = at_least_one(NUM_CNT_REGS),
    localparam int IRQ_A              = at_least_one(IRQ_WIDTH)
) (
    input  logic                Bus2IP_Clk,
    input  logic                Bus2IP_Resetn,
    ipif_regs_ext_if.slave      bus,
    output logic [WO_A*DW-1:0]  wo_regs,
    output logic [RW_A*DW-1:0]  rw_regs,
    input  logic [RO_A*DW-1:0]  ro_regs,
    input  logic [CNT_A-1:0]    cnt_inc,
    input  logic [IRQ_A-1:0]    irq_event,
    output logic                irq
);
    localparam int ADDR_LSB = log2_ceil(BW);
    localparam int TOTAL    = total_regs(NUM_WO_REGS, NUM_RW_REGS, NUM_RO_REGS, NUM_CNT_REGS, IRQ_WIDTH);
    localparam int IDX_W    = at_least_one(log2_ceil(TOTAL));
    localparam int RW_OFF   = NUM_WO_REGS;
    localparam int RO_OFF   = RW_OFF + NUM_RW_REGS;
    localparam int CNT_OFF  = RO_OFF + NUM_RO_REGS;
    localparam int IST_OFF  = CNT_OFF + NUM_CNT_REGS;
    localparam int IEN_OFF  = IST_OFF + 1;

    ipif_state_e state_q, state_d;
    logic rdack_q, rdack_d, wrack_q, wrack_d, err_q, err_d, irq_q;
    logic [DW-1:0] rdata_q, rdata_d, rd_mux_s, wr_mask_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] addr_s;
    logic [31:0] idx_s;
    logic in_range_s, fire_s, rd_fire_s, wr_fire_s;
    logic [WO_A-1:0][DW-1:0] wo_q;
    logic [RW_A-1:0][DW-1:0] rw_q;
    logic [CNT_A-1:0][CNT_WIDTH-1:0] cnt_val_s;
    logic [IRQ_A-1:0] ist_q, ien_q;
    logic unused_s;

    function automatic logic [DW-1:0] be_to_mask(input logic [BW-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < BW; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                                 input logic [DW-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign addr_s     = bus.Bus2IP_Addr;
    assign idx_s      = 32'(addr_s[ADDR_LSB +: IDX_W]);
    assign in_range_s = idx_s < 32'(TOTAL);
    assign wr_mask_s  = be_to_mask(bus.Bus2IP_BE);
    assign fire_s     = (state_q == ST_IDLE) && bus.Bus2IP_CS;
    assign rd_fire_s  = fire_s && bus.Bus2IP_RNW;
    assign wr_fire_s  = fire_s && !bus.Bus2IP_RNW;
    assign unused_s   = ^{addr_s, bus.Bus2IP_Data, cnt_inc, irq_event, ro_regs};

    // Handshake: a strobe is acknowledged once in ACK, then HOLD waits for CS to drop
    always_comb begin
        state_d = state_q;
        rdack_d = 1'b0;
        wrack_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Bus2IP_CS) begin
                    state_d = ST_ACK;
                    rdack_d = bus.Bus2IP_RNW;
                    wrack_d = !bus.Bus2IP_RNW;
                    err_d   = !in_range_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: begin
                if (!bus.Bus2IP_CS) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux: one-hot OR of every readable register; WO and unmapped indices contribute zero
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NUM_RW_REGS; i++)  rd_mux_s |= (idx_s == 32'(RW_OFF + i))  ? rw_q[i] : '0;
        for (int i = 0; i < NUM_RO_REGS; i++)  rd_mux_s |= (idx_s == 32'(RO_OFF + i))  ? ro_regs[i*DW +: DW] : '0;
        for (int i = 0; i < NUM_CNT_REGS; i++) rd_mux_s |= (idx_s == 32'(CNT_OFF + i)) ? DW'(cnt_val_s[i]) : '0;
        rd_mux_s |= (idx_s == 32'(IST_OFF)) ? DW'(ist_q) : '0;
        rd_mux_s |= (idx_s == 32'(IEN_OFF)) ? DW'(ien_q) : '0;
        rdata_d   = (rd_fire_s && in_range_s) ? rd_mux_s : '0;
    end

    // FSM state and registered bus responses
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q <= ST_IDLE;
            rdack_q <= 1'b0;
            wrack_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdack_q <= rdack_d;
            wrack_q <= wrack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            irq_q   <= |(ist_q & ien_q);
        end
    end

    // WO and RW storage, byte-lane merged on the committing write
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            wo_q <= '0;
            rw_q <= '0;
        end else begin
            for (int i = 0; i < NUM_WO_REGS; i++) begin
                if (wr_fire_s && (idx_s == 32'(i))) wo_q[i] <= byte_merge(wo_q[i], bus.Bus2IP_Data, wr_mask_s);
            end
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (wr_fire_s && (idx_s == 32'(RW_OFF + i))) rw_q[i] <= byte_merge(rw_q[i], bus.Bus2IP_Data, wr_mask_s);
            end
        end
    end

    if (NUM_CNT_REGS > 0) begin : g_cnt
        for (genvar g = 0; g < NUM_CNT_REGS; g++) begin : g_inst
            ipif_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk_i  (Bus2IP_Clk),
                .rst_ni (Bus2IP_Resetn),
                .inc_i  (cnt_inc[g]),
                .clr_i  (rd_fire_s && (idx_s == 32'(CNT_OFF + g))),
                .cnt_o  (cnt_val_s[g])
            );
        end
    end else begin : g_no_cnt
        assign cnt_val_s = '0;
    end

    if (IRQ_WIDTH > 0) begin : g_irq
        logic [IRQ_A-1:0] ist_d, ien_d, clr_s;
        assign clr_s = IRQ_A'(bus.Bus2IP_Data & wr_mask_s);

        // Status is W1C with new events winning; enable is a byte-enabled write
        always_comb begin
            ist_d = ist_q;
            ien_d = ien_q;
            if (wr_fire_s && (idx_s == 32'(IST_OFF))) begin
                ist_d = (ist_q & ~clr_s) | irq_event;
            end else begin
                ist_d = ist_q | irq_event;
            end
            if (wr_fire_s && (idx_s == 32'(IEN_OFF))) begin
                ien_d = IRQ_A'(byte_merge(DW'(ien_q), bus.Bus2IP_Data, wr_mask_s));
            end else begin
                ien_d = ien_q;
            end
        end

        // Interrupt status and enable registers
        always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
            if (!Bus2IP_Resetn) begin
                ist_q <= '0;
                ien_q <= '0;
            end else begin
                ist_q <= ist_d;
                ien_q <= ien_d;
            end
        end
    end else begin : g_no_irq
        assign ist_q = '0;
        assign ien_q = '0;
    end

    assign bus.IP2Bus_Data  = rdata_q;
    assign bus.IP2Bus_RdAck = rdack_q;
    assign bus.IP2Bus_WrAck = wrack_q;
    assign bus.IP2Bus_Error = err_q;
    assign wo_regs          = wo_q;
    assign rw_regs          = rw_q;
    assign irq              = irq_q;
endmodule
